// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and bounds for the UART transmit path
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_t;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

  // Mode 2'b11 is reserved and behaves as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// rtl/uart_tx_framer_if.sv - word handshake between the TX source and the framer
interface uart_tx_framer_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [1:0]            parity_mode;
  logic                  in_ready;

  modport master (output in_valid, output in_data, output parity_mode, input in_ready);
  modport slave  (input in_valid, input in_data, input parity_mode, output in_ready);

endinterface

// File: rtl/uart_tx_shreg.sv
// rtl/uart_tx_shreg.sv - loadable shift register presenting one serial bit per shift
module uart_tx_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             sdo
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= MSB_FIRST ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
    end
  end

  assign sdo = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start, data, optional parity, stop bits
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              baud_tick,
  uart_tx_framer_if.slave   up,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t        state, state_nx;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
  logic             stop_cnt, stop_cnt_nx;
  logic             tx_nx, done_nx;
  logic             load, shift, sdo;
  logic             par_en, par_bit;

  uart_tx_shreg #(
    .WIDTH     (DATA_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .shift     (shift),
    .load_data (up.in_data),
    .sdo       (sdo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Parity is captured with the word so later input changes cannot leak into the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      tx       <= tx_nx;
      tx_done  <= done_nx;
      bit_cnt  <= bit_cnt_nx;
      stop_cnt <= stop_cnt_nx;
      if (load) begin
        par_en  <= parity_enabled(up.parity_mode);
        par_bit <= (^up.in_data) ^ (up.parity_mode == PAR_ODD);
      end
    end
  end

  always_comb begin
    state_nx    = state;
    tx_nx       = tx;
    done_nx     = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    bit_cnt_nx  = bit_cnt;
    stop_cnt_nx = stop_cnt;
    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (up.in_valid) begin
          load     = 1'b1;
          state_nx = ARMED;
        end
      end
      ARMED: if (baud_tick) begin
        tx_nx    = 1'b0;
        state_nx = START;
      end
      START: if (baud_tick) begin
        tx_nx      = sdo;
        shift      = 1'b1;
        bit_cnt_nx = '0;
        state_nx   = DATA;
      end
      DATA: if (baud_tick) begin
        if (bit_cnt == BIT_LAST) begin
          stop_cnt_nx = 1'b0;
          if (par_en) begin
            tx_nx    = par_bit;
            state_nx = PARITY;
          end else begin
            tx_nx    = 1'b1;
            state_nx = STOP;
          end
        end else begin
          tx_nx      = sdo;
          shift      = 1'b1;
          bit_cnt_nx = bit_cnt + 1'b1;
        end
      end
      PARITY: if (baud_tick) begin
        tx_nx       = 1'b1;
        stop_cnt_nx = 1'b0;
        state_nx    = STOP;
      end
      STOP: if (baud_tick) begin
        if (stop_cnt == STOP_LAST) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          stop_cnt_nx = stop_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign up.in_ready = (state == IDLE);
  assign busy        = (state != IDLE);

endmodule
